conv_window_frame_ctrl: RTL and testbench

Frame-level sequencer for the 3x3 window buffer with padding.
- Accepts a start command with frame geometry and padding mode.
- Soft-clears the window buffer, then streams W*H pixels from a 1-cycle-latency pixel RAM into it.
- Counts the emitted windows and signals done, or err on bad config or stall.
- Sits between the frame-store RAM and the window buffer / convolution datapath.

---
 rtl/conv_pkg.sv | 45 ++++
 rtl/conv_pix_addr_gen.sv | 54 +++++
 rtl/conv_window_frame_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_conv_window_frame_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types, constants and helpers for the frame-level window sequencer.
package conv_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FEED   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [1:0] PAD_NONE = 2'b00;
    localparam logic [1:0] PAD_ZERO = 2'b01;
    localparam int         PIX_W    = 16;

    // Number of 3x3 windows the buffer emits for a frame of w x h pixels.
    function automatic logic [16:0] exp_windows(input logic [7:0] w,
                                                input logic [7:0] h,
                                                input logic [1:0] pad);
        logic [16:0] ew;
        logic [16:0] eh;
        if (pad == PAD_ZERO) begin
            ew = {9'd0, w};
            eh = {9'd0, h};
        end else begin
            ew = {9'd0, w - 8'd2};
            eh = {9'd0, h - 8'd2};
        end
        return ew * eh;
    endfunction

    // A frame is runnable only if it yields at least one window.
    function automatic logic cfg_ok(input logic [7:0] w,
                                    input logic [7:0] h,
                                    input logic [1:0] pad);
        logic ok;
        ok = (w != 8'd0) && (h != 8'd0) && !pad[1];
        if (pad == PAD_NONE && (w < 8'd3 || h < 8'd3)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/conv_pix_addr_gen.sv
// Raster-order pixel RAM read sequencer with configurable inter-read gap.
module conv_pix_addr_gen
    import conv_pkg::*;
#(
    parameter int PIX_GAP = 0,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_i,
    input  logic              run_i,
    input  logic [15:0]       total_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam int GAP_W = (PIX_GAP > 0) ? $clog2(PIX_GAP + 1) : 1;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    // A read fires whenever the sequencer is running and the gap has elapsed.
    assign rd_en_o = run_i && (gap_q == '0);
    assign addr_o  = addr_q;
    assign last_o  = rd_en_o && (addr_q == ADDR_W'(total_i - 16'd1));

    // Next address and gap countdown.
    always_comb begin
        addr_d = addr_q;
        gap_d  = gap_q;
        if (init_i) begin
            addr_d = '0;
            gap_d  = '0;
        end else if (rd_en_o) begin
            addr_d = addr_q + ADDR_W'(1);
            gap_d  = GAP_W'(PIX_GAP);
        end else if (run_i && gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end
    end

    // Address and gap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            gap_q  <= '0;
        end else begin
            addr_q <= addr_d;
            gap_q  <= gap_d;
        end
    end

endmodule

// File: rtl/conv_window_frame_ctrl.sv
// Frame sequencer: clears the window buffer, streams a frame into it and
// counts the windows that come back, flagging done, bad config, stall or abort.
module conv_window_frame_ctrl
    import conv_pkg::*;
#(
    parameter int CLR_CYCLES    = 2,
    parameter int PIX_GAP       = 0,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int ADDR_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        cfg_width,
    input  logic [7:0]        cfg_height,
    input  logic [1:0]        cfg_padding,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              win_rst_n,
    output logic              win_valid_in,
    output logic [PIX_W-1:0]  win_data_in,
    output logic [7:0]        win_width,
    output logic [7:0]        win_height,
    output logic [1:0]        win_padding,
    input  logic              win_valid_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [16:0]       win_count
);

    localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [3:0]         clr_cnt_q, clr_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
    logic [16:0]        exp_q, exp_d;
    logic [16:0]        count_q, count_d;
    logic [7:0]         width_q, width_d;
    logic [7:0]         height_q, height_d;
    logic [1:0]         pad_q, pad_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               win_rst_n_q, win_rst_n_d;
    logic               valid_q;
    logic               feed_init;
    logic               last_rd;
    logic               abort_ok;
    logic [15:0]        pix_total;

    assign pix_total = {8'd0, width_q} * {8'd0, height_q};
    assign tmo_inc   = tmo_q + TMO_W'(1);
    assign abort_ok  = abort && (state_q == ST_CLEAR || state_q == ST_FEED ||
                                 state_q == ST_DRAIN);

    conv_pix_addr_gen #(
        .PIX_GAP (PIX_GAP),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .init_i  (feed_init),
        .run_i   (state_q == ST_FEED),
        .total_i (pix_total),
        .rd_en_o (mem_rd_en),
        .addr_o  (mem_addr),
        .last_o  (last_rd)
    );

    // Next-state, window counting, watchdog and pulse generation.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        tmo_d       = '0;
        exp_d       = exp_q;
        count_d     = count_q;
        width_d     = width_q;
        height_d    = height_q;
        pad_d       = pad_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        win_rst_n_d = 1'b1;
        feed_init   = 1'b0;

        // The buffer soft reset runs off one countdown, whether it was
        // started by a new frame or by an abort.
        if (clr_cnt_q > 4'd1) begin
            clr_cnt_d   = clr_cnt_q - 4'd1;
            win_rst_n_d = 1'b0;
        end else begin
            clr_cnt_d = 4'd0;
        end

        if ((state_q == ST_FEED || state_q == ST_DRAIN) && win_valid_out &&
            count_q < exp_q) begin
            count_d = count_q + 17'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    width_d  = cfg_width;
                    height_d = cfg_height;
                    pad_d    = cfg_padding;
                    count_d  = '0;
                    exp_d    = exp_windows(cfg_width, cfg_height, cfg_padding);
                    if (cfg_ok(cfg_width, cfg_height, cfg_padding)) begin
                        state_d     = ST_CLEAR;
                        clr_cnt_d   = 4'(CLR_CYCLES);
                        win_rst_n_d = 1'b0;
                        feed_init   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q <= 4'd1) begin
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (last_rd) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_q == exp_q) begin
                    state_d = ST_FINISH;
                end else if (!win_valid_out) begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_W'(DRAIN_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_ok) begin
            state_d     = ST_IDLE;
            clr_cnt_d   = 4'(CLR_CYCLES);
            win_rst_n_d = 1'b0;
            err_d       = 1'b1;
            done_d      = 1'b0;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clr_cnt_q   <= 4'd0;
            tmo_q       <= '0;
            exp_q       <= '0;
            count_q     <= '0;
            width_q     <= '0;
            height_q    <= '0;
            pad_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            win_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            tmo_q       <= tmo_d;
            exp_q       <= exp_d;
            count_q     <= count_d;
            width_q     <= width_d;
            height_q    <= height_d;
            pad_q       <= pad_d;
            done_q      <= done_d;
            err_q       <= err_d;
            win_rst_n_q <= win_rst_n_d;
        end
    end

    // Pixel valid trails the read strobe by the RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= mem_rd_en;
        end
    end

    assign win_data_in  = mem_rd_data;
    assign win_valid_in = valid_q;
    assign win_rst_n    = win_rst_n_q;
    assign win_width    = width_q;
    assign win_height   = height_q;
    assign win_padding  = pad_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign win_count    = count_q;

endmodule

// File: tb/tb_conv_window_frame_ctrl.sv
// Directed bench for the frame sequencer with a RAM model, a simple window
// buffer model and an address scoreboard; two instances cover PIX_GAP 0 and 2.
module tb_conv_window_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cfg_width = 8'd0;
    logic [7:0]  cfg_height = 8'd0;
    logic [1:0]  cfg_padding = 2'd0;
    logic        sel = 1'b0;
    logic [15:0] ram_q = 16'd0;
    logic        wvo = 1'b0;

    logic        rd_en0, rd_en1, wrst0, wrst1, wvi0, wvi1, busy0, busy1;
    logic        done0, done1, err0, err1;
    logic [15:0] addr0, addr1, wdat0, wdat1;
    logic [7:0]  ww0, ww1, wh0, wh1;
    logic [1:0]  wp0, wp1;
    logic [16:0] wc0, wc1;

    conv_window_frame_ctrl #(.CLR_CYCLES(2), .PIX_GAP(0), .DRAIN_TIMEOUT(16), .ADDR_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_padding(cfg_padding),
        .mem_rd_en(rd_en0), .mem_addr(addr0), .mem_rd_data(ram_q),
        .win_rst_n(wrst0), .win_valid_in(wvi0), .win_data_in(wdat0),
        .win_width(ww0), .win_height(wh0), .win_padding(wp0),
        .win_valid_out(wvo), .busy(busy0), .done(done0), .err(err0), .win_count(wc0));

    conv_window_frame_ctrl #(.CLR_CYCLES(2), .PIX_GAP(2), .DRAIN_TIMEOUT(16), .ADDR_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_padding(cfg_padding),
        .mem_rd_en(rd_en1), .mem_addr(addr1), .mem_rd_data(ram_q),
        .win_rst_n(wrst1), .win_valid_in(wvi1), .win_data_in(wdat1),
        .win_width(ww1), .win_height(wh1), .win_padding(wp1),
        .win_valid_out(wvo), .busy(busy1), .done(done1), .err(err1), .win_count(wc1));

    // Selected-instance view
    logic        m_rd_en, m_wrst, m_wvi, m_busy, m_done, m_err;
    logic [15:0] m_addr, m_wdat;
    logic [7:0]  m_ww, m_wh;
    logic [1:0]  m_wp;
    logic [16:0] m_wc;
    assign m_rd_en = sel ? rd_en1 : rd_en0;
    assign m_addr  = sel ? addr1  : addr0;
    assign m_wrst  = sel ? wrst1  : wrst0;
    assign m_wvi   = sel ? wvi1   : wvi0;
    assign m_wdat  = sel ? wdat1  : wdat0;
    assign m_ww    = sel ? ww1    : ww0;
    assign m_wh    = sel ? wh1    : wh0;
    assign m_wp    = sel ? wp1    : wp0;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_done  = sel ? done1  : done0;
    assign m_err   = sel ? err1   : err0;
    assign m_wc    = sel ? wc1    : wc0;

    function automatic logic [15:0] pix(input logic [15:0] a);
        return {a[7:0], ~a[7:0]} ^ 16'h3C5A;
    endfunction

    // 1-cycle-latency pixel RAM
    always @(posedge clk) begin
        if (m_rd_en) ram_q <= pix(m_addr);
    end

    // Window buffer model: one window per pixel with zero padding, otherwise
    // one per pixel at row>=2 and col>=2; tie0 silences it.
    int cur_w = 1;
    int cur_pad = 0;
    int mdl_cnt = 0;
    logic tie0 = 1'b0;
    always @(posedge clk) begin
        if (!m_wrst) begin
            mdl_cnt <= 0;
            wvo     <= 1'b0;
        end else begin
            wvo <= 1'b0;
            if (m_wvi) begin
                mdl_cnt <= mdl_cnt + 1;
                if (!tie0)
                    wvo <= (cur_pad == 1) ? 1'b1 :
                           ((mdl_cnt / cur_w) >= 2 && (mdl_cnt % cur_w) >= 2);
            end
        end
    end

    int total = 0;
    int bad = 0;
    int addr_q[$];
    int step_idx = 0, rd_cnt = 0, last_rd_step = 0, exp_gap = 0;
    int done_cnt = 0, err_cnt = 0, err_step = 0, clr_low = 0;
    logic busy_seen = 1'b0;
    logic prev_rd_en = 1'b0;
    logic [15:0] prev_addr = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        rd_cnt = 0; done_cnt = 0; err_cnt = 0; clr_low = 0; busy_seen = 1'b0;
    endtask

    // Advance one cycle and monitor the selected instance at the falling edge.
    task automatic step();
        int exp_a;
        @(negedge clk);
        step_idx++;
        if (m_rd_en) begin
            if (addr_q.size() > 0) exp_a = addr_q.pop_front();
            else exp_a = -1;
            chk("rd_addr", {16'd0, m_addr}, exp_a);
            if (rd_cnt > 0) chk("rd_spacing", step_idx - last_rd_step, exp_gap + 1);
            rd_cnt++;
            last_rd_step = step_idx;
        end
        if (m_wvi || prev_rd_en) chk("valid_in_lag", m_wvi, prev_rd_en);
        if (m_wvi) chk("pix_data", m_wdat, pix(prev_addr));
        if (m_done) begin
            done_cnt++;
            chk("busy_at_done", m_busy, 0);
        end
        if (m_err) begin
            err_cnt++;
            err_step = step_idx;
        end
        if (m_busy) busy_seen = 1'b1;
        if (!m_wrst) clr_low++;
        prev_rd_en = m_rd_en;
        prev_addr  = m_addr;
    endtask

    task automatic start_frame(input int w, input int h, input int pad);
        logic ok;
        cur_w = (w > 0) ? w : 1;
        cur_pad = pad;
        cfg_width = 8'(w); cfg_height = 8'(h); cfg_padding = 2'(pad);
        ok = (w != 0) && (h != 0) && (pad < 2) && (pad == 1 || (w >= 3 && h >= 3));
        addr_q.delete();
        if (ok) for (int i = 0; i < w * h; i++) addr_q.push_back(i);
        clear_stats();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input int maxc);
        int n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < maxc) begin
            step();
            n++;
        end
        chk("frame_end_bound", ((done_cnt + err_cnt) > 0) ? 1 : 0, 1);
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_rd_en", m_rd_en, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        chk("rst_err", m_err, 0);
        chk("rst_count", m_wc, 0);
        chk("rst_width", m_ww, 0);
        chk("rst_valid_in", m_wvi, 0);
        chk("rst_win_rst_n", m_wrst, 0);
        rst_n = 1'b1;
        step();
        chk("win_rst_n_release", m_wrst, 1);

        // 5x4 no padding, back-to-back reads
        start_frame(5, 4, 0);
        wait_end(200);
        chk("t1_busy_at_done", m_busy, 0);
        step(); step(); step();
        chk("t1_clr_low", clr_low, 2);
        chk("t1_reads", rd_cnt, 20);
        chk("t1_count", m_wc, 6);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_queue_empty", addr_q.size(), 0);
        chk("t1_geom", {m_ww, m_wh, 6'd0, m_wp}, {8'd5, 8'd4, 6'd0, 2'd0});

        // 4x4 zero padding, with an ignored start mid-frame
        start_frame(4, 4, 1);
        for (int n = 0; n < 100 && rd_cnt < 3; n++) step();
        cfg_width = 8'd9; start = 1'b1;
        step();
        start = 1'b0; cfg_width = 8'd4;
        wait_end(200);
        step(); step();
        chk("t2_reads", rd_cnt, 16);
        chk("t2_count", m_wc, 16);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_err_cnt", err_cnt, 0);
        chk("t2_width_kept", m_ww, 4);

        // Illegal configs
        start_frame(2, 8, 0);
        chk("t3a_err_pulse", m_err, 1);
        step();
        chk("t3a_err_clear", m_err, 0);
        step(); step();
        chk("t3a_no_reads", rd_cnt, 0);
        chk("t3a_no_busy", busy_seen, 0);
        chk("t3a_no_clear", clr_low, 0);
        start_frame(5, 5, 2);
        chk("t3b_err_pulse", m_err, 1);
        step(); step();
        chk("t3b_err_cnt", err_cnt, 1);
        chk("t3b_no_reads", rd_cnt, 0);
        chk("t3b_no_busy", busy_seen, 0);

        // PIX_GAP=2, 3x3 no padding
        sel = 1'b1; exp_gap = 2;
        step();
        start_frame(3, 3, 0);
        wait_end(300);
        step(); step();
        chk("t4_reads", rd_cnt, 9);
        chk("t4_count", m_wc, 1);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_err_cnt", err_cnt, 0);
        sel = 1'b0; exp_gap = 0;
        step();

        // Drain timeout with no windows
        tie0 = 1'b1;
        start_frame(3, 3, 0);
        wait_end(200);
        chk("t5_busy_at_err", m_busy, 0);
        chk("t5_err_delay", err_step - last_rd_step, 17);
        step(); step();
        chk("t5_err_cnt", err_cnt, 1);
        chk("t5_done_cnt", done_cnt, 0);
        chk("t5_count", m_wc, 0);
        tie0 = 1'b0;

        // Abort on the 7th read of a 5x5 frame, then a clean frame
        start_frame(5, 5, 0);
        for (int n = 0; n < 100 && rd_cnt < 7; n++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        addr_q.delete();
        chk("t6_rd_off", m_rd_en, 0);
        chk("t6_err_pulse", m_err, 1);
        chk("t6_busy_low", m_busy, 0);
        chk("t6_wrst_low1", m_wrst, 0);
        step();
        chk("t6_wrst_low2", m_wrst, 0);
        step();
        chk("t6_wrst_high", m_wrst, 1);
        chk("t6_reads", rd_cnt, 7);
        start_frame(5, 5, 0);
        wait_end(300);
        step(); step();
        chk("t6b_reads", rd_cnt, 25);
        chk("t6b_count", m_wc, 9);
        chk("t6b_done_cnt", done_cnt, 1);
        chk("t6b_err_cnt", err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
